// File: rtl/spi_8_channel_pwm_driver.sv
// Eight-channel PWM generator with a shared free-running period counter and per-channel duty registers.
// Optional macro PWM_SHADOW_UPDATE_EN: duty changes take effect only at the next period start.
`timescale 1ns/1ps
module spi_8_channel_pwm_driver #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned LEVEL_W  = 3,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [LEVEL_W-1:0]  level,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam int unsigned        PERIOD   = (1 << LEVEL_W) - 1;
  localparam logic [LEVEL_W-1:0] CNT_LAST = LEVEL_W'(PERIOD - 1);

  logic [LEVEL_W-1:0]               cnt_q, cnt_d;
  logic [CHANNELS-1:0][LEVEL_W-1:0] duty_q, duty_d;
  logic [CHANNELS-1:0][LEVEL_W-1:0] duty_eff;
  logic [CHANNELS-1:0]              pwm_q, pwm_d;
  logic                             wrap;

  // Period counter runs 0..PERIOD-1 so the all-ones level is never reached (always-on)
  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    cnt_d = wrap ? '0 : cnt_q + LEVEL_W'(1);
  end

  // Out-of-range addresses match no channel and are dropped
  always_comb begin
    duty_d = duty_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (pset && (addr == ADDR_W'(i))) begin
        duty_d[i] = level;
      end
    end
  end

`ifdef PWM_SHADOW_UPDATE_EN
  logic [CHANNELS-1:0][LEVEL_W-1:0] shadow_q, shadow_d;

  // Shadow copies the written duty only when a new period begins
  always_comb begin
    shadow_d = wrap ? duty_q : shadow_q;
    duty_eff = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  always_comb begin
    duty_eff = duty_q;
  end
`endif

  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (cnt_q < duty_eff[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_spi_8_channel_pwm_driver.sv
// Self-checking bench for spi_8_channel_pwm_driver: table-driven duty checks, corner sequences
// and randomized writes compared against a period/duty reference model.
`timescale 1ns/1ps
module tb_spi_8_channel_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pset = 1'b0;
  logic [2:0] addr = '0;
  logic [2:0] level = '0;
  logic [7:0] pwm_out;

  int checks = 0;
  int passed = 0;

  // Reference model: edges since reset, requested duties, effective duties
  int         n_edges;
  int         duty_m [8];
  int         eff_m  [8];
  logic [7:0] exp_pwm;

  spi_8_channel_pwm_driver dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pset   (pset),
    .addr   (addr),
    .level  (level),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    n_edges = 0;
    exp_pwm = '0;
    for (int i = 0; i < 8; i++) begin
      duty_m[i] = 0;
      eff_m[i]  = 0;
    end
  endtask

  // One rising edge: output from the pre-edge phase and effective duty, then state updates
  task automatic model_step(input logic p, input logic [2:0] a, input logic [2:0] l);
    int phase;
    phase = n_edges % 7;
    for (int i = 0; i < 8; i++) begin
`ifdef PWM_SHADOW_UPDATE_EN
      exp_pwm[i] = (phase < eff_m[i]);
`else
      exp_pwm[i] = (phase < duty_m[i]);
`endif
    end
    if (phase == 6) begin
      for (int i = 0; i < 8; i++) eff_m[i] = duty_m[i];
    end
    if (p) duty_m[a] = int'(l);
    n_edges++;
  endtask

  task automatic cyc(input logic p, input logic [2:0] a, input logic [2:0] l);
    pset  = p;
    addr  = a;
    level = l;
    @(posedge clk);
    model_step(p, a, l);
    #1;
    chk("pwm_model", 32'(pwm_out), 32'(exp_pwm));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'(i), 3'(i * 3));
  endtask

  task automatic reset_mid_run();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 32'(pwm_out), 32'h0);
    for (int i = 0; i < 5; i++) begin
      pset  = 1'b1;
      addr  = 3'($urandom_range(0, 7));
      level = 3'($urandom_range(1, 7));
      @(posedge clk);
      #1;
      chk("reset_hold", 32'(pwm_out), 32'h0);
    end
    pset = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] ch;
    logic [2:0] lvl;
    int         exp_high;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cnt;
    vecs[0] = '{ch: 3'd1, lvl: 3'd2, exp_high: 2};
    vecs[1] = '{ch: 3'd6, lvl: 3'd5, exp_high: 5};
    vecs[2] = '{ch: 3'd2, lvl: 3'd7, exp_high: 7};
    vecs[3] = '{ch: 3'd2, lvl: 3'd0, exp_high: 0};
    vecs[4] = '{ch: 3'd4, lvl: 3'd1, exp_high: 1};
    vecs[5] = '{ch: 3'd0, lvl: 3'd6, exp_high: 6};

    model_reset();
    #1;
    chk("reset_initial", 32'(pwm_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single channel at level 3: three highs aligned to period start
    cyc(1'b1, 3'd3, 3'd3);
    idle(21);

    // Extremes: level 0 and level 7 must never toggle
    cyc(1'b1, 3'd0, 3'd0);
    cyc(1'b1, 3'd7, 3'd7);
    idle(9);
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 3'd0, 3'd0);
      chk("ch0_const0", 32'(pwm_out[0]), 32'h0);
      chk("ch7_const1", 32'(pwm_out[7]), 32'h1);
    end

    // Back-to-back writes with pset held: channel i high i clocks per period
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 3'(i));
    idle(9);
    for (int ch = 0; ch < 8; ch++) begin
      cnt = 0;
      for (int k = 0; k < 7; k++) begin
        cyc(1'b0, 3'd0, 3'd0);
        cnt += int'(pwm_out[ch]);
      end
      chk("ramp_high_count", 32'(cnt), 32'(ch));
    end

    // Table-driven single writes measured over a full period
    foreach (vecs[v]) begin
      cyc(1'b1, vecs[v].ch, vecs[v].lvl);
      idle(9);
      cnt = 0;
      for (int k = 0; k < 7; k++) begin
        cyc(1'b0, 3'd0, 3'd0);
        cnt += int'(pwm_out[vecs[v].ch]);
      end
      chk("table_high_count", 32'(cnt), 32'(vecs[v].exp_high));
    end

    // Mid-period overwrite of ch5 from 6 to 1, write landing on the phase-3 edge
    cyc(1'b1, 3'd5, 3'd6);
    idle(14);
    while ((n_edges % 7) != 3) cyc(1'b0, 3'd0, 3'd0);
    cyc(1'b1, 3'd5, 3'd1);
    chk("overwrite_edge", 32'(pwm_out[5]), 32'h1);
    cyc(1'b0, 3'd0, 3'd0);
`ifdef PWM_SHADOW_UPDATE_EN
    chk("overwrite_next", 32'(pwm_out[5]), 32'h1);
`else
    chk("overwrite_next", 32'(pwm_out[5]), 32'h0);
`endif
    idle(16);

    // Strobe low with wandering addr/level leaves every output on its model waveform
    for (int i = 0; i < 20; i++) cyc(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Asynchronous reset mid-run with write pulses, then recovery from phase 0
    reset_mid_run();
    idle(8);
    cyc(1'b1, 3'd2, 3'd4);
    idle(14);

    // Randomized writes against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    reset_mid_run();
    idle(7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
